// File: rtl/tlb_fill_ctrl.sv
// TLB entry RAM write-side controller: accepts walker fills, picks a victim
// (first invalid entry, else tree pseudo-LRU) and strobes a one-hot write.
module tlb_fill_ctrl #(
    parameter int unsigned TLB_ENTRIES = 8,
    parameter int unsigned PTE_BITS    = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   FillValid,
    output logic                   FillReady,
    input  logic [PTE_BITS-1:0]    FillPTE,
    input  logic                   TLBHit,
    input  logic [TLB_ENTRIES-1:0] Matches,
    input  logic                   Flush,
    output logic [TLB_ENTRIES-1:0] WriteEnables,
    output logic [PTE_BITS-1:0]    PTE,
    output logic [TLB_ENTRIES-1:0] Valid,
    output logic                   FillDone
);

    localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);
    localparam int unsigned NODES = TLB_ENTRIES - 1;

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e                 r_state;
    logic [TLB_ENTRIES-1:0] r_valid;
    logic [NODES-1:0]       r_plru;
    logic [PTE_BITS-1:0]    r_pte;
    logic [IDX_W-1:0]       r_victim;
    logic [TLB_ENTRIES-1:0] r_we;
    logic                   r_done;

    logic [IDX_W-1:0]       w_first_inv;
    logic                   w_any_inv;
    logic [IDX_W-1:0]       w_plru_victim;
    logic [IDX_W-1:0]       w_victim;
    logic [IDX_W-1:0]       w_hit_idx;
    logic [NODES-1:0]       w_plru_hit;
    logic [NODES-1:0]       w_plru_fill;

    // Heap-ordered tree: node k has children 2k+1 (lower half) and 2k+2 (upper half).
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] p,
                                                    input logic [IDX_W-1:0] e);
        logic [NODES-1:0] q;
        logic             dir;
        int               node;
        q    = p;
        node = 0;
        for (int l = 0; l < int'(IDX_W); l++) begin
            dir     = e[int'(IDX_W) - 1 - l];
            q[node] = ~dir;
            node    = 2 * node + 1 + (dir ? 1 : 0);
        end
        return q;
    endfunction

    function automatic logic [IDX_W-1:0] plru_walk(input logic [NODES-1:0] p);
        int node;
        node = 0;
        for (int l = 0; l < int'(IDX_W); l++) begin
            node = 2 * node + 1 + (p[node] ? 1 : 0);
        end
        return IDX_W'(node - int'(NODES));
    endfunction

    always_comb begin
        w_any_inv   = 1'b0;
        w_first_inv = '0;
        for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_any_inv   = 1'b1;
                w_first_inv = IDX_W'(i);
            end
        end
        w_plru_victim = plru_walk(r_plru);
        w_victim      = w_any_inv ? w_first_inv : w_plru_victim;
    end

    always_comb begin
        w_hit_idx = '0;
        for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
            if (Matches[i]) begin
                w_hit_idx = w_hit_idx | IDX_W'(i);
            end
        end
        w_plru_hit  = TLBHit ? plru_touch(r_plru, w_hit_idx) : r_plru;
        // Fill touch applied on top of the hit touch, so the fill wins shared nodes.
        w_plru_fill = plru_touch(w_plru_hit, r_victim);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_valid  <= '0;
            r_plru   <= '0;
            r_pte    <= '0;
            r_victim <= '0;
            r_we     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_we   <= '0;
            r_done <= 1'b0;
            if (Flush) begin
                r_valid <= '0;
                r_plru  <= '0;
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_plru <= w_plru_hit;
                        if (FillValid) begin
                            r_pte    <= FillPTE;
                            r_victim <= w_victim;
                            r_we     <= TLB_ENTRIES'(1) << w_victim;
                            r_done   <= 1'b1;
                            r_state  <= StWrite;
                        end
                    end
                    StWrite: begin
                        r_valid[r_victim] <= 1'b1;
                        r_plru            <= w_plru_fill;
                        r_state           <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    // A flush in the write cycle suppresses the strobe that cycle.
    assign FillReady    = (r_state == StIdle) && !Flush;
    assign WriteEnables = Flush ? '0 : r_we;
    assign FillDone     = r_done && !Flush;
    assign PTE          = r_pte;
    assign Valid        = r_valid;

    hit_onehot_a: assert property (@(posedge clk) disable iff (!reset_n)
        TLBHit |-> $onehot(Matches));

endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// Directed testbench for tlb_fill_ctrl (8 entries, 64-bit PTE).
module tb_tlb_fill_ctrl;

    logic        clk;
    logic        reset_n;
    logic        FillValid;
    logic        FillReady;
    logic [63:0] FillPTE;
    logic        TLBHit;
    logic [7:0]  Matches;
    logic        Flush;
    logic [7:0]  WriteEnables;
    logic [63:0] PTE;
    logic [7:0]  Valid;
    logic        FillDone;

    int n_total;
    int n_pass;

    tlb_fill_ctrl #(
        .TLB_ENTRIES(8),
        .PTE_BITS   (64)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .FillValid   (FillValid),
        .FillReady   (FillReady),
        .FillPTE     (FillPTE),
        .TLBHit      (TLBHit),
        .Matches     (Matches),
        .Flush       (Flush),
        .WriteEnables(WriteEnables),
        .PTE         (PTE),
        .Valid       (Valid),
        .FillDone    (FillDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        FillValid = 1'b0;
        FillPTE   = '0;
        TLBHit    = 1'b0;
        Matches   = '0;
        Flush     = 1'b0;

        // 1. reset state and a single fill
        cyc();
        cyc();
        check("rst_we", 64'(WriteEnables), 64'h0);
        check("rst_valid", 64'(Valid), 64'h0);
        check("rst_done", 64'(FillDone), 64'h0);
        check("rst_pte", PTE, 64'h0);
        reset_n = 1'b1;
        settle();
        check("rst_ready", 64'(FillReady), 64'h1);
        FillValid = 1'b1;
        FillPTE   = 64'h0000_0000_2000_00CF;
        cyc();
        FillValid = 1'b0;
        FillPTE   = 64'hDEAD_BEEF_DEAD_BEEF;
        settle();
        check("t1_we", 64'(WriteEnables), 64'h01);
        check("t1_pte", PTE, 64'h0000_0000_2000_00CF);
        check("t1_done", 64'(FillDone), 64'h1);
        check("t1_ready_wr", 64'(FillReady), 64'h0);
        cyc();
        settle();
        check("t1_valid", 64'(Valid), 64'h01);
        check("t1_ready", 64'(FillReady), 64'h1);
        check("t1_we_idle", 64'(WriteEnables), 64'h0);
        check("t1_pte_hold", PTE, 64'h0000_0000_2000_00CF);

        // 2. eight back-to-back fills from empty
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        cyc();
        FillValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            FillPTE = 64'(i + 16);
            settle();
            check("t2_ready_hi", 64'(FillReady), 64'h1);
            check("t2_we_idle", 64'(WriteEnables), 64'h0);
            cyc();
            settle();
            check("t2_we", 64'(WriteEnables), 64'h1 << i);
            check("t2_ready_lo", 64'(FillReady), 64'h0);
            check("t2_pte", PTE, 64'(i + 16));
            cyc();
        end
        settle();
        check("t2_valid", 64'(Valid), 64'hFF);

        // 3. ninth fill via PLRU, then hit on entry 0 steers next fill to entry 4
        cyc();
        FillValid = 1'b0;
        settle();
        check("t3_we_plru", 64'(WriteEnables), 64'h01);
        cyc();
        TLBHit  = 1'b1;
        Matches = 8'h01;
        cyc();
        TLBHit    = 1'b0;
        Matches   = 8'h00;
        FillValid = 1'b1;
        cyc();
        FillValid = 1'b0;
        settle();
        check("t3_we_hit", 64'(WriteEnables), 64'h10);
        cyc();

        // 4. flush during the write cycle
        FillValid = 1'b1;
        cyc();
        FillValid = 1'b0;
        Flush     = 1'b1;
        settle();
        check("t4_we_flush", 64'(WriteEnables), 64'h0);
        check("t4_done_flush", 64'(FillDone), 64'h0);
        cyc();
        Flush = 1'b0;
        settle();
        check("t4_valid", 64'(Valid), 64'h00);
        check("t4_ready", 64'(FillReady), 64'h1);
        FillValid = 1'b1;
        cyc();
        FillValid = 1'b0;
        settle();
        check("t4_we_refill", 64'(WriteEnables), 64'h01);
        cyc();

        // 5. flush in idle blocks the handshake
        Flush     = 1'b1;
        FillValid = 1'b1;
        settle();
        check("t5_ready_lo", 64'(FillReady), 64'h0);
        cyc();
        settle();
        check("t5_no_we", 64'(WriteEnables), 64'h0);
        check("t5_no_done", 64'(FillDone), 64'h0);
        check("t5_valid", 64'(Valid), 64'h00);
        Flush = 1'b0;
        settle();
        check("t5_ready_hi", 64'(FillReady), 64'h1);
        cyc();
        FillValid = 1'b0;
        settle();
        check("t5_we", 64'(WriteEnables), 64'h01);
        cyc();

        // 6. async reset in the middle of a write
        FillValid = 1'b1;
        cyc();
        FillValid = 1'b0;
        settle();
        check("t6_we_pre", 64'(WriteEnables), 64'h02);
        check("t6_valid_pre", 64'(Valid), 64'h01);
        reset_n = 1'b0;
        #1;
        check("t6_we_rst", 64'(WriteEnables), 64'h0);
        check("t6_valid_rst", 64'(Valid), 64'h0);
        check("t6_done_rst", 64'(FillDone), 64'h0);
        cyc();
        reset_n = 1'b1;
        settle();
        check("t6_ready", 64'(FillReady), 64'h1);
        cyc();
        settle();
        check("t6_we_idle", 64'(WriteEnables), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
